// File: rtl/ram2_ctrl_pkg.sv
// Shared definitions for the RAM2 SRAM controller.
// - Request-strobe polarities and the zero data word.
// - Controller FSM state encoding.
// - Requester port identifiers.
package ram2_ctrl_pkg;

  localparam logic        RamChipEnable = 1'b1;
  localparam logic        ReadEnable    = 1'b1;
  localparam logic        WriteEnable   = 1'b1;
  localparam logic [31:0] ZeroWord      = 32'h0000_0000;

  typedef enum logic [2:0] {
    Ram2Idle    = 3'd0,
    Ram2Rd      = 3'd1,
    Ram2WrSetup = 3'd2,
    Ram2WrPulse = 3'd3,
    Ram2WrHold  = 3'd4
  } ram2_state_e;

  typedef enum logic {
    Ram2PortIf  = 1'b0,
    Ram2PortMem = 1'b1
  } ram2_port_e;

endpackage

// File: rtl/ram2_arb.sv
// Winner select between the IF and MEM requesters of the RAM2 controller.
// Build option RAM2_CTRL_RR_EN: round-robin on contention using a last-grant
// register (reset to IF); otherwise fixed priority with MEM first.
// Ports:
//   clk, rst, accept - only present with RAM2_CTRL_RR_EN; accept marks a cycle
//                      in which a valid grant is actually taken
//   if_req, mem_req  - already-qualified requests
//   grant_valid      - at least one request present
//   grant_port       - winning port
module ram2_arb
  import ram2_ctrl_pkg::*;
(
`ifdef RAM2_CTRL_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       accept,
`endif
  input  logic       if_req,
  input  logic       mem_req,
  output logic       grant_valid,
  output ram2_port_e grant_port
);

  assign grant_valid = if_req | mem_req;

`ifdef RAM2_CTRL_RR_EN
  ram2_port_e last_q;

  always_comb begin
    grant_port = Ram2PortIf;
    if (if_req && mem_req) begin
      // On contention the port that did not win last time goes first.
      grant_port = (last_q == Ram2PortIf) ? Ram2PortMem : Ram2PortIf;
    end else if (mem_req) begin
      grant_port = Ram2PortMem;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= Ram2PortIf;
    end else if (accept && grant_valid) begin
      last_q <= grant_port;
    end
  end
`else
  assign grant_port = mem_req ? Ram2PortMem : Ram2PortIf;
`endif

endmodule

// File: rtl/ram2_ctrl.sv
// Sequencer/arbiter for the single-port RAM2 SRAM shared by instruction fetch
// and the MEM stage. One access at a time, programmable strobe wait states,
// one-cycle ready pulse per completed access, combinational stall request.
// Build option RAM2_CTRL_RR_EN selects round-robin arbitration (see ram2_arb).
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   if_re_i/if_addr_i            - IF read request and word address
//   if_inst_o/if_ready_o         - IF read data and completion pulse
//   mem_ce_i/re_i/we_i           - MEM enable and read/write request
//   mem_addr_i/mem_data_i        - MEM word address and write data
//   mem_data_o/mem_ready_o       - MEM read data and completion pulse
//   stallreq_o                   - pipeline stall while a request is unserved
//   ram_*                        - registered SRAM address, data and strobes
module ram2_ctrl
  import ram2_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_re_i,
  input  logic [31:0]       if_addr_i,
  output logic [31:0]       if_inst_o,
  output logic              if_ready_o,
  input  logic              mem_ce_i,
  input  logic              mem_re_i,
  input  logic              mem_we_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic [31:0]       mem_data_o,
  output logic              mem_ready_o,
  output logic              stallreq_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i,
  output logic              ram_data_oe_o,
  output logic              ram_ce_n_o,
  output logic              ram_oe_n_o,
  output logic              ram_we_n_o
);

  localparam logic [2:0] WaitInit = 3'(WAIT_CYCLES);

  ram2_state_e state_q;
  ram2_port_e  port_q;
  logic [2:0]  cnt_q;

  logic       mem_req;
  logic       mem_is_wr;
  logic       grant_valid;
  ram2_port_e grant_port;

  assign mem_req   = (mem_ce_i == RamChipEnable) &&
                     ((mem_re_i == ReadEnable) || (mem_we_i == WriteEnable));
  assign mem_is_wr = (mem_we_i == WriteEnable);

  assign stallreq_o = (mem_req && !mem_ready_o) || (if_re_i && !if_ready_o);

  // A port in its ready cycle still holds its old request; mask it so the
  // completed access is not issued a second time.
  ram2_arb u_arb (
`ifdef RAM2_CTRL_RR_EN
    .clk         (clk),
    .rst         (rst),
    .accept      (state_q == Ram2Idle),
`endif
    .if_req      (if_re_i && !if_ready_o),
    .mem_req     (mem_req && !mem_ready_o),
    .grant_valid (grant_valid),
    .grant_port  (grant_port)
  );

  if (ADDR_W < 32) begin : g_addr_unused
    logic unused_addr;
    assign unused_addr = ^{if_addr_i[31:ADDR_W], mem_addr_i[31:ADDR_W]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= Ram2Idle;
      port_q        <= Ram2PortIf;
      cnt_q         <= 3'd0;
      ram_addr_o    <= '0;
      ram_data_o    <= ZeroWord;
      ram_data_oe_o <= 1'b0;
      ram_ce_n_o    <= 1'b1;
      ram_oe_n_o    <= 1'b1;
      ram_we_n_o    <= 1'b1;
      if_inst_o     <= ZeroWord;
      mem_data_o    <= ZeroWord;
      if_ready_o    <= 1'b0;
      mem_ready_o   <= 1'b0;
    end else begin
      if_ready_o  <= 1'b0;
      mem_ready_o <= 1'b0;
      unique case (state_q)
        Ram2Idle: begin
          if (grant_valid) begin
            port_q     <= grant_port;
            ram_ce_n_o <= 1'b0;
            ram_addr_o <= (grant_port == Ram2PortMem) ? mem_addr_i[ADDR_W-1:0]
                                                      : if_addr_i[ADDR_W-1:0];
            if ((grant_port == Ram2PortMem) && mem_is_wr) begin
              ram_data_o    <= mem_data_i;
              ram_data_oe_o <= 1'b1;
              state_q       <= Ram2WrSetup;
            end else begin
              ram_oe_n_o <= 1'b0;
              cnt_q      <= WaitInit;
              state_q    <= Ram2Rd;
            end
          end
        end
        Ram2Rd: begin
          if (cnt_q == 3'd0) begin
            ram_ce_n_o <= 1'b1;
            ram_oe_n_o <= 1'b1;
            if (port_q == Ram2PortMem) begin
              mem_data_o  <= ram_data_i;
              mem_ready_o <= 1'b1;
            end else begin
              if_inst_o  <= ram_data_i;
              if_ready_o <= 1'b1;
            end
            state_q <= Ram2Idle;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        Ram2WrSetup: begin
          ram_we_n_o <= 1'b0;
          cnt_q      <= WaitInit;
          state_q    <= Ram2WrPulse;
        end
        Ram2WrPulse: begin
          if (cnt_q == 3'd0) begin
            ram_we_n_o  <= 1'b1;
            mem_ready_o <= 1'b1;
            state_q     <= Ram2WrHold;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        Ram2WrHold: begin
          ram_ce_n_o    <= 1'b1;
          ram_data_oe_o <= 1'b0;
          state_q       <= Ram2Idle;
        end
        default: begin
          ram_ce_n_o    <= 1'b1;
          ram_oe_n_o    <= 1'b1;
          ram_we_n_o    <= 1'b1;
          ram_data_oe_o <= 1'b0;
          state_q       <= Ram2Idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram2_ctrl.sv
// Bench for ram2_ctrl: transaction-level timing model plus directed literal
// checks, and a second instance with zero wait states.
module tb_ram2_ctrl;

  localparam int unsigned AW = 18;
  localparam int unsigned W  = 1;
  localparam int unsigned W0 = 0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        if_re, mem_ce, mem_re, mem_we;
  logic [31:0] if_addr, mem_addr, mem_data;
  logic [31:0] if_inst, mem_data_o, ram_data_o, ram_data_i;
  logic        if_ready, mem_ready, stallreq, ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;
  logic [AW-1:0] ram_addr;

  ram2_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .if_re_i(if_re), .if_addr_i(if_addr), .if_inst_o(if_inst), .if_ready_o(if_ready),
    .mem_ce_i(mem_ce), .mem_re_i(mem_re), .mem_we_i(mem_we), .mem_addr_i(mem_addr),
    .mem_data_i(mem_data), .mem_data_o(mem_data_o), .mem_ready_o(mem_ready),
    .stallreq_o(stallreq), .ram_addr_o(ram_addr), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .ram_data_oe_o(ram_data_oe), .ram_ce_n_o(ram_ce_n),
    .ram_oe_n_o(ram_oe_n), .ram_we_n_o(ram_we_n)
  );

  // Zero-wait-state instance, IF port only.
  logic        z_if_re;
  logic [31:0] z_if_addr, z_if_inst, z_mem_data_o, z_ram_data_o, z_ram_data_i;
  logic        z_if_ready, z_mem_ready, z_stallreq, z_ram_data_oe, z_ram_ce_n, z_ram_oe_n;
  logic        z_ram_we_n;
  logic [AW-1:0] z_ram_addr;

  ram2_ctrl #(.ADDR_W(AW), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .rst(rst),
    .if_re_i(z_if_re), .if_addr_i(z_if_addr), .if_inst_o(z_if_inst), .if_ready_o(z_if_ready),
    .mem_ce_i(1'b0), .mem_re_i(1'b0), .mem_we_i(1'b0), .mem_addr_i(32'h0),
    .mem_data_i(32'h0), .mem_data_o(z_mem_data_o), .mem_ready_o(z_mem_ready),
    .stallreq_o(z_stallreq), .ram_addr_o(z_ram_addr), .ram_data_o(z_ram_data_o),
    .ram_data_i(z_ram_data_i), .ram_data_oe_o(z_ram_data_oe), .ram_ce_n_o(z_ram_ce_n),
    .ram_oe_n_o(z_ram_oe_n), .ram_we_n_o(z_ram_we_n)
  );
  assign z_ram_data_i = {14'h0, z_ram_addr} ^ 32'hC0DE_0000;

  // SRAM contents: a fixed pattern until a word is written.
  function automatic logic [31:0] init_word(input logic [9:0] idx);
    return (idx == 10'd16) ? 32'h3C01_1234 : ({idx, 22'h2A5F3} ^ 32'h1234_5678);
  endfunction

  logic [31:0] sram [1024];
  bit          sram_valid [1024];

  always_comb begin
    ram_data_i = 32'h0;
    if (!ram_ce_n && !ram_oe_n) begin
      ram_data_i = sram_valid[ram_addr[9:0]] ? sram[ram_addr[9:0]] : init_word(ram_addr[9:0]);
    end
  end

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n && ram_data_oe) begin
      sram[ram_addr[9:0]]       <= ram_data_o;
      sram_valid[ram_addr[9:0]] <= 1'b1;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks only the latest access and its accept edge; every strobe and pulse
  // follows from the cycle offset since that edge.
  logic [31:0] ref_mem [1024];
  bit          ref_valid [1024];
  int unsigned cyc;
  bit          acc_v, acc_wr, acc_mem, last_mem, m_if_r, m_mem_r, m_free, m_take_mem;
  int unsigned acc_t, m_d;
  logic [AW-1:0] acc_addr, e_addr;
  logic [31:0] acc_wdata, e_wdata, e_inst, e_mdata;
  logic        e_ce_n, e_oe_n, e_we_n, e_doe, e_if_rdy, e_mem_rdy;

  function automatic logic [31:0] ref_rd(input logic [9:0] idx);
    return ref_valid[idx] ? ref_mem[idx] : init_word(idx);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; acc_v = 1'b0; last_mem = 1'b0;
      e_ce_n = 1'b1; e_oe_n = 1'b1; e_we_n = 1'b1; e_doe = 1'b0;
      e_if_rdy = 1'b0; e_mem_rdy = 1'b0;
      e_inst = 32'h0; e_mdata = 32'h0; e_addr = '0; e_wdata = 32'h0;
    end else begin
      cyc = cyc + 1;
      m_if_r  = if_re && !e_if_rdy;
      m_mem_r = mem_ce && (mem_re || mem_we) && !e_mem_rdy;
      m_free  = !acc_v || (cyc >= acc_t + (acc_wr ? W + 4 : W + 2));
      if (m_free && (m_if_r || m_mem_r)) begin
        if (m_if_r && m_mem_r) begin
`ifdef RAM2_CTRL_RR_EN
          m_take_mem = !last_mem;
`else
          m_take_mem = 1'b1;
`endif
        end else begin
          m_take_mem = m_mem_r;
        end
        last_mem  = m_take_mem;
        acc_v     = 1'b1;
        acc_t     = cyc;
        acc_mem   = m_take_mem;
        acc_wr    = m_take_mem && mem_we;
        acc_addr  = m_take_mem ? mem_addr[AW-1:0] : if_addr[AW-1:0];
        acc_wdata = mem_data;
      end
      e_if_rdy = 1'b0; e_mem_rdy = 1'b0;
      e_ce_n = 1'b1; e_oe_n = 1'b1; e_we_n = 1'b1; e_doe = 1'b0;
      if (acc_v) begin
        m_d = cyc - acc_t;
        if (m_d == 0) begin
          e_addr = acc_addr;
          if (acc_wr) e_wdata = acc_wdata;
        end
        if (!acc_wr) begin
          if (m_d <= W) begin
            e_ce_n = 1'b0; e_oe_n = 1'b0;
          end else if (m_d == W + 1) begin
            if (acc_mem) begin
              e_mem_rdy = 1'b1; e_mdata = ref_rd(acc_addr[9:0]);
            end else begin
              e_if_rdy = 1'b1; e_inst = ref_rd(acc_addr[9:0]);
            end
          end
        end else begin
          if (m_d <= W + 2) begin
            e_ce_n = 1'b0; e_doe = 1'b1;
          end
          if (m_d >= 1 && m_d <= W + 1) e_we_n = 1'b0;
          if (m_d == W + 2) begin
            e_mem_rdy = 1'b1;
            ref_mem[acc_addr[9:0]]   = acc_wdata;
            ref_valid[acc_addr[9:0]] = 1'b1;
          end
        end
      end
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("ram_ce_n", {31'h0, ram_ce_n}, {31'h0, e_ce_n});
      check("ram_oe_n", {31'h0, ram_oe_n}, {31'h0, e_oe_n});
      check("ram_we_n", {31'h0, ram_we_n}, {31'h0, e_we_n});
      check("ram_data_oe", {31'h0, ram_data_oe}, {31'h0, e_doe});
      check("if_ready", {31'h0, if_ready}, {31'h0, e_if_rdy});
      check("mem_ready", {31'h0, mem_ready}, {31'h0, e_mem_rdy});
      check("if_inst", if_inst, e_inst);
      check("mem_data", mem_data_o, e_mdata);
      check("stallreq", {31'h0, stallreq},
            {31'h0, (mem_ce && (mem_re || mem_we) && !e_mem_rdy) || (if_re && !e_if_rdy)});
      if (!e_ce_n) check("ram_addr", {14'h0, ram_addr}, {14'h0, e_addr});
      if (e_doe) check("ram_data_out", ram_data_o, e_wdata);
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic wait_rdy(input bit sel_mem, output int edges, output bit ok);
    edges = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      edges++;
      if (sel_mem ? mem_ready : if_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("ready_within_bound", {31'h0, ok}, 32'h1);
  endtask

  task automatic if_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    int e; bit ok;
    @(posedge clk); #2;
    if_re = 1'b1; if_addr = a;
    wait_rdy(1'b0, e, ok);
    check({name, "_latency"}, 32'(e), 32'(W + 2));
    check({name, "_data"}, if_inst, exp);
    #1 if_re = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] t;
    t = $urandom();
    return {t[31:18], 12'h0, t[5:0]};
  endfunction

  int  edges, we_low, dup;
  bit  ok, first_mem;
  bit  exp_first [3];
  logic [31:0] t32;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    if_re = 0; if_addr = 0; mem_ce = 0; mem_re = 0; mem_we = 0; mem_addr = 0; mem_data = 0;
    z_if_re = 0; z_if_addr = 0;
`ifdef RAM2_CTRL_RR_EN
    exp_first = '{1'b1, 1'b0, 1'b1};
`else
    exp_first = '{1'b1, 1'b1, 1'b1};
`endif
    #1 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // IF read, W=1: ready 2 edges after acceptance, one cycle wide, held request
    @(posedge clk); #2;
    if_re = 1'b1; if_addr = 32'h0000_0010;
    #1 check("stall_pending", {31'h0, stallreq}, 32'h1);
    wait_rdy(1'b0, edges, ok);
    check("if_rd_latency", 32'(edges), 32'(W + 2));
    check("if_rd_data", if_inst, 32'h3C01_1234);
    check("stall_in_ready", {31'h0, stallreq}, 32'h0);
    @(posedge clk); #1;
    check("if_ready_width", {31'h0, if_ready}, 32'h0);
    #1 if_re = 1'b0;
    dup = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (if_ready) dup++;
    end
    check("if_no_duplicate", 32'(dup), 32'h0);

    // MEM write then read-back
    @(posedge clk); #2;
    mem_ce = 1; mem_we = 1; mem_re = 0; mem_addr = 32'h0000_0200; mem_data = 32'hDEAD_BEEF;
    we_low = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!ram_we_n) we_low++;
      if (mem_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("wr_done", {31'h0, ok}, 32'h1);
    check("we_low_cycles", 32'(we_low), 32'(W + 1));
    #1 mem_we = 0; mem_re = 1; mem_data = 32'h0;
    wait_rdy(1'b1, edges, ok);
    check("mem_readback", mem_data_o, 32'hDEAD_BEEF);
    #1 mem_ce = 0; mem_re = 0;
    repeat (2) @(posedge clk);

    // Contention rounds; an IF-only read first leaves last-grant at IF.
    if_read(32'h0000_0011, init_word(10'd17), "pre_contention");
    for (int r = 0; r < 3; r++) begin
      @(posedge clk); #2;
      if_re = 1; if_addr = 32'h20 + 32'(r);
      mem_ce = 1; mem_re = 1; mem_we = 0; mem_addr = 32'h30 + 32'(r);
      first_mem = 1'b0; ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk); #1;
        if (mem_ready || if_ready) begin
          first_mem = mem_ready; ok = 1'b1;
          break;
        end
      end
      #1 if_re = 0; mem_ce = 0; mem_re = 0;
      check("contention_done", {31'h0, ok}, 32'h1);
      check("contention_winner_is_mem", {31'h0, first_mem}, {31'h0, exp_first[r]});
      repeat (3) @(posedge clk);
    end

    // Asynchronous reset in the middle of a read
    @(posedge clk); #2;
    if_re = 1; if_addr = 32'h0000_0040;
    @(posedge clk); #1;
    check("rst_rd_started", {31'h0, ram_ce_n}, 32'h0);
    #2 rst = 1'b1;
    #1;
    check("rst_ce_n", {31'h0, ram_ce_n}, 32'h1);
    check("rst_oe_n", {31'h0, ram_oe_n}, 32'h1);
    check("rst_we_n", {31'h0, ram_we_n}, 32'h1);
    check("rst_data_oe", {31'h0, ram_data_oe}, 32'h0);
    check("rst_if_inst", if_inst, 32'h0);
    if_re = 0;
    @(posedge clk); #3 rst = 1'b0;
    dup = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (if_ready || mem_ready) dup++;
    end
    check("rst_no_ready", 32'(dup), 32'h0);
    if_read(32'h0000_0010, 32'h3C01_1234, "post_rst");

    // W=0 instance: ready 1 edge after acceptance, held request not repeated
    @(posedge clk); #2;
    z_if_re = 1; z_if_addr = 32'h0000_0055;
    ok = 1'b0; edges = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      edges++;
      if (z_if_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("w0_done", {31'h0, ok}, 32'h1);
    check("w0_latency", 32'(edges), 32'(W0 + 2));
    check("w0_data", z_if_inst, 32'hC0DE_0055);
    @(posedge clk); #2 z_if_re = 0;
    dup = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (z_if_ready) dup++;
    end
    check("w0_no_duplicate", 32'(dup), 32'h0);

    // Random traffic; requests are held until their ready pulse.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #2;
      if (!if_re || if_ready) begin
        if_re   = ($urandom_range(0, 99) < 55);
        if_addr = rand_addr();
      end
      if (!(mem_ce && (mem_re || mem_we)) || mem_ready) begin
        t32      = $urandom();
        mem_ce   = (t32[3:0] != 4'h0);
        mem_re   = t32[4];
        mem_we   = t32[5] & t32[6];
        if (t32[9:7] == 3'h0) mem_ce = 1'b0;
        mem_addr = rand_addr();
        mem_data = $urandom();
      end
    end
    if_re = 0; mem_ce = 0; mem_re = 0; mem_we = 0;
    repeat (10) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
